// File: rtl/nrzi_pkg.sv
// ---------------------------------------------------------------------------
// nrzi_pkg
//   Types and constants shared by the NRZI transmit and receive line blocks.
//   - nrzi_state_t    : serializer sequencer states
//   - NRZI_IDLE_LEVEL : line level driven out of reset
// ---------------------------------------------------------------------------
package nrzi_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DATA  = 2'd1,
      S_STUFF = 2'd2
   } nrzi_state_t;

   localparam logic NRZI_IDLE_LEVEL = 1'b0;

endpackage : nrzi_pkg

// File: rtl/nrzi_bit_timer.sv
// ---------------------------------------------------------------------------
// nrzi_bit_timer
//   Divides Clk down to one bit period of CLKS_PER_BIT cycles.
//   Ports:
//     Clk     in  clock, posedge
//     Clr     in  synchronous active-high reset
//     start   in  restart the period count (word accepted)
//     enable  in  count while a bit period is being transmitted
//     bit_end out high in the last cycle of each bit period
// ---------------------------------------------------------------------------
module nrzi_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic Clk,
   input  logic Clr,
   input  logic start,
   input  logic enable,
   output logic bit_end
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge Clk) begin
      if (Clr || start)
         cnt <= '0;
      else if (enable)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   assign bit_end = enable && (cnt == LAST);

endmodule : nrzi_bit_timer

// File: rtl/nrzi_tx_serializer.sv
// ---------------------------------------------------------------------------
// nrzi_tx_serializer
//   Parallel-in, serial-out NRZI transmitter. A WIDTH-bit word is taken over
//   a valid/ready handshake and sent LSB first; a 1 toggles Tx, a 0 holds it.
//   Optional bit stuffing (macro NRZI_TX_STUFF_EN): after STUFF_LEN
//   consecutive 0 bits an extra toggling period is inserted so a downstream
//   transition detector never loses lock.
//   Ports:
//     Clk        in  clock, posedge
//     Clr        in  synchronous active-high reset
//     Din        in  [WIDTH] word to transmit
//     DinValid   in  Din valid
//     DinReady   out block idle, can accept a word
//     Tx         out registered NRZI line
//     TxBitValid out high during every transmitted period (data or stuffed)
//     TxStuff    out high during a stuffed period (0 without the macro)
//     Done       out one-cycle pulse after the last period of a word
// ---------------------------------------------------------------------------
module nrzi_tx_serializer
   import nrzi_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter int unsigned STUFF_LEN    = 6
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic [WIDTH-1:0] Din,
   input  logic             DinValid,
   output logic             DinReady,
   output logic             Tx,
   output logic             TxBitValid,
   output logic             TxStuff,
   output logic             Done
);

   if (WIDTH < 1) begin : g_chk_width
      $error("nrzi_tx_serializer: WIDTH must be >= 1");
   end
   if (CLKS_PER_BIT < 1) begin : g_chk_cpb
      $error("nrzi_tx_serializer: CLKS_PER_BIT must be >= 1");
   end
   if (STUFF_LEN < 1) begin : g_chk_stuff
      $error("nrzi_tx_serializer: STUFF_LEN must be >= 1");
   end

   localparam int unsigned BW = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

   nrzi_state_t      state, state_n;
   logic             tx_q, tx_n;
   logic             done_q, done_n;
   logic [WIDTH-1:0] sr, sr_n, sr_sh;   // sr[0] is the bit on the line now
   logic [BW-1:0]    idx, idx_n;
   logic             accept, bit_end, adv, last;

`ifdef NRZI_TX_STUFF_EN
   localparam int unsigned ZW = $clog2(STUFF_LEN + 1);
   localparam logic [ZW-1:0] ZRUN_MAX = ZW'(STUFF_LEN);
   logic [ZW-1:0] zrun, zrun_n, zrun_inc;
   assign zrun_inc = zrun + 1'b1;
`endif

   assign accept = DinValid && (state == S_IDLE);
   assign sr_sh  = sr >> 1;
   assign last   = (idx == LAST_IDX);

   nrzi_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .Clk     (Clk),
      .Clr     (Clr),
      .start   (accept),
      .enable  (state != S_IDLE),
      .bit_end (bit_end)
   );

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state  <= S_IDLE;
         tx_q   <= NRZI_IDLE_LEVEL;
         done_q <= 1'b0;
         sr     <= '0;
         idx    <= '0;
`ifdef NRZI_TX_STUFF_EN
         zrun   <= '0;
`endif
      end else begin
         state  <= state_n;
         tx_q   <= tx_n;
         done_q <= done_n;
         sr     <= sr_n;
         idx    <= idx_n;
`ifdef NRZI_TX_STUFF_EN
         zrun   <= zrun_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      tx_n    = tx_q;
      done_n  = 1'b0;
      sr_n    = sr;
      idx_n   = idx;
      adv     = 1'b0;
`ifdef NRZI_TX_STUFF_EN
      zrun_n  = zrun;
`endif
      case (state)
         S_IDLE: begin
            if (accept) begin
               sr_n    = Din;
               tx_n    = tx_q ^ Din[0];
               idx_n   = '0;
               state_n = S_DATA;
`ifdef NRZI_TX_STUFF_EN
               zrun_n  = '0;
`endif
            end
         end
         S_DATA: begin
            if (bit_end) begin
`ifdef NRZI_TX_STUFF_EN
               // The run is scored when a 0 period finishes; reaching the
               // limit inserts a forced toggle before the pending bit.
               if (!sr[0] && (zrun_inc == ZRUN_MAX)) begin
                  state_n = S_STUFF;
                  tx_n    = ~tx_q;
                  zrun_n  = '0;
               end else begin
                  zrun_n  = sr[0] ? '0 : zrun_inc;
                  adv     = 1'b1;
               end
`else
               adv = 1'b1;
`endif
            end
         end
`ifdef NRZI_TX_STUFF_EN
         S_STUFF: begin
            if (bit_end)
               adv = 1'b1;
         end
`endif
         default: state_n = S_IDLE;
      endcase

      // Move to the next data bit, or finish the word.
      if (adv) begin
         if (last) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
         end else begin
            state_n = S_DATA;
            idx_n   = idx + 1'b1;
            sr_n    = sr_sh;
            tx_n    = tx_q ^ sr_sh[0];
         end
      end
   end

   assign DinReady   = (state == S_IDLE);
   assign TxBitValid = (state != S_IDLE);
   assign Tx         = tx_q;
   assign Done       = done_q;
`ifdef NRZI_TX_STUFF_EN
   assign TxStuff    = (state == S_STUFF);
`else
   assign TxStuff    = 1'b0;
`endif

endmodule : nrzi_tx_serializer
